i_cache: RTL and testbench
==========================

I_CACHE -- requirements
Module: i_cache

Interface
REQ-001 Parameter: CPUID, default 0, selects which per-CPU slot of cache_control_if this cache drives and reads.
REQ-002 Ports: one clock; reset is synchronous and active-low.
- CLK  in  1  system clock, all state updates on rising edge.
- nRST  in  1  synchronous active-low reset.
REQ-003 Datapath side (datapath_cache_if, icache modport):
- imemREN  in  1  instruction fetch request.
- imemaddr  in  32  byte address of the instruction.
- ihit  out  1  requested word valid on imemload this cycle.
- imemload  out  32  instruction word.
REQ-004 Memory side (cache_control_if, icache modport, index [CPUID]):
- iREN  out  1  fill request.
- iaddr  out  32  fill address.
- iwait  in  1  memory busy; fill data valid when low.
- iload  in  32  fill data.

Function
REQ-005 Organisation: direct-mapped, 16 frames, one 32-bit word per frame; address split tag[31:6], idx[5:2], bytoff[1:0] (bytoff ignored).
REQ-006 Each frame holds valid bit, 26-bit tag, 32-bit data.
REQ-007 Hit = imemREN & frame[idx].valid & (frame[idx].tag == tag); combinational, same cycle as request.
REQ-008 On hit: ihit=1, imemload=frame[idx].data, iREN=0.
REQ-009 imemREN=0: ihit=0, iREN=0, imemload=0, no state change.
REQ-010 Miss (imemREN=1, not hit): state IDLE -> FETCH; in FETCH drive iREN=1, iaddr=imemaddr (full address, bytoff included), ihit=0, imemload=0.
REQ-011 FETCH: while iwait=1 hold request; on first rising edge with iwait=0 write frame[idx] <= {valid=1, tag, iload}, return to IDLE; the following cycle produces a hit.
REQ-012 Miss-to-hit latency: 2 cycles minimum with zero-wait memory (request cycle + fill cycle, hit in cycle 3 at latest relative to request edge).
REQ-013 Replacement: fill overwrites frame unconditionally (conflict miss evicts old tag).
REQ-014 imemREN dropped or imemaddr changed during FETCH: abort, return to IDLE, no frame write.
REQ-015 iaddr SHALL equal imemaddr whenever iREN=0 (don't-care to memory, defined for waveforms).

Reset
REQ-016 nRST=0 at rising edge: all valid bits, tags, data cleared to 0, state IDLE, perf counters 0.
REQ-017 Reset mid-FETCH abandons fill; no frame written; after reset all outputs ihit=0, iREN=0, imemload=0 until a request arrives.

Configuration
REQ-018 Macro ICACHE_PERF_EN: when defined, module adds outputs hit_count and miss_count (32 bits each); hit_count increments once per cycle with ihit=1, miss_count once per IDLE->FETCH transition; both saturate at all-ones. When undefined, ports and counters absent; functional behaviour identical.

Structure
REQ-019 Package cpu_types_pkg holds word_t (32-bit), icachef_t packed struct {tag 26, idx 4, bytoff 2}, and constants ICACHE_FRAMES=16, ITAG_W=26, IIDX_W=4.
REQ-020 Single optional sub-module icache_frames: 16-entry valid/tag/data array, one synchronous write port, one combinational read port, synchronous clear.

Verification
REQ-021 Reset, read 0x04 with memory word 0x8C010004 -> first cycle ihit=0, iREN=1, iaddr=0x04; after iwait=0 next cycle ihit=1, imemload=0x8C010004, iREN=0.
REQ-022 Re-read 0x04 repeatedly -> ihit=1 every cycle, iREN never asserted; read 0x00 -> compulsory miss then hit.
REQ-023 Conflict: after 0x04 cached, read 0x44 (idx 1) -> miss, fill; read 0x04 -> miss again with iaddr=0x04.
REQ-024 Fill loop 0x00..0x24 step 4 (10 words), then re-read all -> 10 hits, data equal to RAM contents.
REQ-025 Hold iwait=1 for 5 cycles during miss -> iREN and iaddr stable, ihit=0 throughout; pulse nRST mid-FETCH -> no frame valid afterward, next read of same address misses.
REQ-026 With ICACHE_PERF_EN: REQ-021 + REQ-022 sequence (3 reads of 0x04) -> miss_count=1, hit_count>=3.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: word and address-field layouts, frame geometry,
// and the fill FSM state encodings.
package cpu_types_pkg;

  localparam int ICACHE_FRAMES = 16;
  localparam int ITAG_W        = 26;
  localparam int IIDX_W        = 4;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  localparam logic [0:0] ICACHE_IDLE  = 1'b0;
  localparam logic [0:0] ICACHE_FETCH = 1'b1;

endpackage

// File: rtl/icache_frames.sv
// Frame store for the direct-mapped I-cache. It holds valid/tag/data for each frame and has
// one synchronous write port, a combinational read port, and a synchronous active-low clear.
module icache_frames
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wen_i,
  input  logic [IIDX_W-1:0] widx_i,
  input  logic [ITAG_W-1:0] wtag_i,
  input  word_t             wdata_i,
  input  logic [IIDX_W-1:0] ridx_i,
  output logic              rvalid_o,
  output logic [ITAG_W-1:0] rtag_o,
  output word_t             rdata_o
);

  logic [ICACHE_FRAMES-1:0] valid_vec;
  logic [ITAG_W-1:0]        tag_arr  [ICACHE_FRAMES];
  word_t                    data_arr [ICACHE_FRAMES];

  // One register set per frame so the clear reaches every entry in a single cycle.
  for (genvar gi = 0; gi < ICACHE_FRAMES; gi++) begin : g_frame
    logic              v_q;
    logic [ITAG_W-1:0] t_q;
    word_t             d_q;

    always_ff @(posedge CLK) begin
      if (!nRST) begin
        v_q <= 1'b0;
        t_q <= '0;
        d_q <= '0;
      end else if (wen_i && (widx_i == IIDX_W'(gi))) begin
        v_q <= 1'b1;
        t_q <= wtag_i;
        d_q <= wdata_i;
      end
    end

    assign valid_vec[gi] = v_q;
    assign tag_arr[gi]   = t_q;
    assign data_arr[gi]  = d_q;
  end

  assign rvalid_o = valid_vec[ridx_i];
  assign rtag_o   = tag_arr[ridx_i];
  assign rdata_o  = data_arr[ridx_i];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped 16 x 1-word instruction cache that returns hits in the same cycle and has
// a two-state fill FSM. Defining ICACHE_PERF_EN adds saturating hit_count/miss_count outputs.
module i_cache
  import cpu_types_pkg::*;
#(
  parameter int CPUID = 0
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
`ifdef ICACHE_PERF_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  // The per-CPU slot is selected by the parent's wiring; nothing inside depends on it.
  localparam int CPUID_UNUSED = CPUID;

  icachef_t          req;
  logic              frame_valid;
  logic [ITAG_W-1:0] frame_tag;
  word_t             frame_data;
  logic              hit;
  logic              same_req;
  logic              fill;
  logic [0:0]        state_q, state_d;
  word_t             addr_q, addr_d;

  assign req = icachef_t'(imemaddr);

  icache_frames u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .wen_i    (fill),
    .widx_i   (req.idx),
    .wtag_i   (req.tag),
    .wdata_i  (iload),
    .ridx_i   (req.idx),
    .rvalid_o (frame_valid),
    .rtag_o   (frame_tag),
    .rdata_o  (frame_data)
  );

  assign hit      = imemREN & frame_valid & (frame_tag == req.tag);
  assign same_req = imemREN & (imemaddr == addr_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fill    = 1'b0;
    iREN    = 1'b0;
    case (state_q)
      ICACHE_IDLE: begin
        if (imemREN && !hit) begin
          state_d = ICACHE_FETCH;
          addr_d  = imemaddr;
        end
      end
      ICACHE_FETCH: begin
        // A dropped or redirected request abandons the fill without touching the frame.
        if (!same_req) begin
          state_d = ICACHE_IDLE;
        end else begin
          iREN = 1'b1;
          if (!iwait) begin
            fill    = 1'b1;
            state_d = ICACHE_IDLE;
          end
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ICACHE_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign ihit     = hit;
  assign imemload = hit ? frame_data : '0;
  assign iaddr    = imemaddr;

`ifdef ICACHE_PERF_EN
  word_t hit_count_q, miss_count_q;
  logic  miss_start;

  assign miss_start = (state_q == ICACHE_IDLE) && (state_d == ICACHE_FETCH);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit && (hit_count_q != '1))
        hit_count_q <= hit_count_q + 32'd1;
      if (miss_start && (miss_count_q != '1))
        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_i_cache.sv
// Directed self-checking bench for i_cache. Memory word at address a is 0x8C010000 | a.
// Performance-counter checks are active only when ICACHE_PERF_EN is defined.
module tb_i_cache;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST = 1'b0;
  logic  imemREN = 1'b0;
  logic  iwait = 1'b1;
  word_t imemaddr = '0;
  word_t iload = '0;
  logic  ihit, iREN;
  word_t imemload, iaddr;
`ifdef ICACHE_PERF_EN
  word_t hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  i_cache #(.CPUID(0)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  function automatic word_t mem_word(input word_t a);
    return 32'h8C01_0000 | a;
  endfunction

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Full miss transaction: request cycle, FETCH with optional wait states, fill, then hit.
  task automatic read_miss(input word_t a, input int waits);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    iload    = '0;
    #1;
    check("miss_ihit", 32'(ihit), 32'd0);
    step();
    check("fetch_iren", 32'(iREN), 32'd1);
    check("fetch_iaddr", iaddr, a);
    check("fetch_ihit", 32'(ihit), 32'd0);
    check("fetch_load", imemload, 32'd0);
    for (int w = 0; w < waits; w++) begin
      step();
      check("wait_iren", 32'(iREN), 32'd1);
      check("wait_iaddr", iaddr, a);
      check("wait_ihit", 32'(ihit), 32'd0);
    end
    iwait = 1'b0;
    iload = mem_word(a);
    step();
    iwait = 1'b1;
    iload = '0;
    check("fill_ihit", 32'(ihit), 32'd1);
    check("fill_data", imemload, mem_word(a));
    check("fill_iren", 32'(iREN), 32'd0);
    $display("read 0x%08h miss waits=%0d -> ihit=%0d data=0x%08h", a, waits, ihit, imemload);
  endtask

  task automatic read_hit(input word_t a);
    imemREN  = 1'b1;
    imemaddr = a;
    #1;
    check("hit_ihit", 32'(ihit), 32'd1);
    check("hit_data", imemload, mem_word(a));
    check("hit_iren", 32'(iREN), 32'd0);
    $display("read 0x%08h hit -> ihit=%0d data=0x%08h", a, ihit, imemload);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    nRST = 1'b0;
    step();
    step();
    check("rst_ihit", 32'(ihit), 32'd0);
    check("rst_iren", 32'(iREN), 32'd0);
    check("rst_load", imemload, 32'd0);
`ifdef ICACHE_PERF_EN
    check("rst_hit_cnt", hit_count, 32'd0);
    check("rst_miss_cnt", miss_count, 32'd0);
`endif
    $display("reset -> ihit=%0d iREN=%0d imemload=0x%08h", ihit, iREN, imemload);
    nRST = 1'b1;
    step();

    // First fetch, then repeated hits.
    read_miss(32'h04, 0);
    read_hit(32'h04);
    read_hit(32'h04);
    read_hit(32'h04);
`ifdef ICACHE_PERF_EN
    check("perf_miss_cnt", miss_count, 32'd1);
    check("perf_hit_ge3", 32'(hit_count >= 32'd3), 32'd1);
`endif

    // With no request, outputs stay quiet even for a cached address.
    imemREN  = 1'b0;
    imemaddr = 32'h04;
    #1;
    check("idle_ihit", 32'(ihit), 32'd0);
    check("idle_load", imemload, 32'd0);
    check("idle_iren", 32'(iREN), 32'd0);
    check("idle_iaddr", iaddr, 32'h04);
    $display("no request at 0x04 -> ihit=%0d iREN=%0d", ihit, iREN);
    step();

    // Compulsory miss on 0x00, then the conflict pair 0x44 and 0x04 on idx 1.
    read_miss(32'h00, 0);
    read_hit(32'h00);
    read_miss(32'h44, 0);
    read_hit(32'h44);
    read_miss(32'h04, 0);

    // Fill 0x00..0x24 (0x00 and 0x04 are already resident), then re-read all ten.
    for (int i = 0; i < 10; i++) begin
      if (i < 2) read_hit(32'(i * 4));
      else       read_miss(32'(i * 4), 0);
    end
    for (int i = 0; i < 10; i++) read_hit(32'(i * 4));

    // Slow memory: five wait states.
    read_miss(32'h30, 5);
    read_hit(32'h30);

    // Redirect during FETCH: the returned data must not be written.
    imemREN  = 1'b1;
    imemaddr = 32'h28;
    #1;
    step();
    check("abort_fetch_iren", 32'(iREN), 32'd1);
    imemaddr = 32'h2C;
    iwait    = 1'b0;
    iload    = mem_word(32'h28);
    step();
    iwait    = 1'b1;
    iload    = '0;
    imemaddr = 32'h28;
    #1;
    check("abort_no_fill", 32'(ihit), 32'd0);
    $display("abort fill of 0x00000028 -> ihit=%0d", ihit);
    imemREN = 1'b0;
    step();

    // Reset during FETCH, with memory answering on that same edge.
    imemREN  = 1'b1;
    imemaddr = 32'h50;
    #1;
    step();
    check("rstf_fetch_iren", 32'(iREN), 32'd1);
    nRST  = 1'b0;
    iwait = 1'b0;
    iload = mem_word(32'h50);
    step();
    nRST    = 1'b1;
    iwait   = 1'b1;
    iload   = '0;
    imemREN = 1'b0;
    #1;
    check("rstf_ihit", 32'(ihit), 32'd0);
    check("rstf_iren", 32'(iREN), 32'd0);
    check("rstf_load", imemload, 32'd0);
    imemREN  = 1'b1;
    imemaddr = 32'h50;
    #1;
    check("rstf_miss_50", 32'(ihit), 32'd0);
    imemaddr = 32'h04;
    #1;
    check("rstf_miss_04", 32'(ihit), 32'd0);
    $display("reset mid-fetch -> 0x50 ihit=%0d, 0x04 ihit=%0d", ihit, ihit);
    imemREN = 1'b0;
    step();
    read_miss(32'h50, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
